// File: rtl/usb_rx_packet_buffer.sv
// Packet-aware USB receive buffer: holds each packet tentatively, commits it on EOP, rolls it back on error/overflow.
// Latency: a committed packet's first byte is visible on out_* the cycle after the packet_done edge.
// Backpressure: out_ready stalls the read side only; the writer has no stall, so a full buffer drops the packet and pulses overflow.
// Optional: define USB_RX_BUF_STATS_EN for the saturating dropped_pkts counter; otherwise dropped_pkts is 0.

module usb_rx_packet_buffer #(
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              write_enable,
    input  logic              rcv_error,
    input  logic              packet_done,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W:0]   pkt_avail,
    output logic              overflow,
    output logic [7:0]        dropped_pkts
);

    localparam logic [ADDR_W:0]   PTR_ONE  = 1;
    localparam logic [ADDR_W-1:0] IDX_ONE  = 1;
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

    // ST_DROP: the packet in flight has already been rejected; swallow bytes until its packet_done
    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } rx_state_t;

    rx_state_t state_q, state_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr;
    logic [ADDR_W:0] wr_ptr_d, commit_ptr_d;
    logic [ADDR_W:0] wr_next;
    logic [ADDR_W:0] occupancy;
    logic            full;
    logic            tent_empty;

    logic            ovf_d;
    logic            pkt_inc;
    logic            pkt_dec;
    logic            mem_we;
    logic            last_we;
    logic            last_val;
    logic [ADDR_W-1:0] last_addr;

    logic [ADDR_W-1:0] rd_idx;
    logic              rd_fire;

    logic [7:0] mem      [DEPTH];
    logic       last_mem [DEPTH];

    // Full is judged on registered pointers, so a same-cycle read does not free a slot for this write
    assign occupancy  = wr_ptr - rd_ptr;
    assign full       = (occupancy == FULL_CNT);
    assign tent_empty = (wr_ptr == commit_ptr);
    assign wr_next    = wr_ptr + PTR_ONE;

    // Write-side next state: error beats everything, then drop mode, then overflow, then normal write/commit
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr;
        commit_ptr_d = commit_ptr;
        ovf_d        = 1'b0;
        pkt_inc      = 1'b0;
        mem_we       = 1'b0;
        last_we      = 1'b0;
        last_val     = 1'b0;
        last_addr    = wr_ptr[ADDR_W-1:0];

        if (rcv_error) begin
            // Roll back the tentative bytes; a simultaneous EOP closes the bad packet right away
            wr_ptr_d = commit_ptr;
            state_d  = packet_done ? ST_ACCEPT : ST_DROP;
        end else if (state_q == ST_DROP) begin
            if (packet_done) begin
                wr_ptr_d = commit_ptr;
                state_d  = ST_ACCEPT;
            end
        end else if (write_enable && full) begin
            // Refused byte poisons the whole packet; if it was also the EOP byte the packet is closed here
            ovf_d    = 1'b1;
            wr_ptr_d = commit_ptr;
            state_d  = packet_done ? ST_ACCEPT : ST_DROP;
        end else begin
            if (write_enable) begin
                mem_we   = 1'b1;
                last_we  = 1'b1;
                last_val = packet_done;
                wr_ptr_d = wr_next;
                if (packet_done) begin
                    commit_ptr_d = wr_next;
                    pkt_inc      = 1'b1;
                end
            end else if (packet_done && !tent_empty) begin
                // EOP arrives after the final byte: mark the most recently written byte
                last_we      = 1'b1;
                last_val     = 1'b1;
                last_addr    = wr_ptr[ADDR_W-1:0] - IDX_ONE;
                commit_ptr_d = wr_ptr;
                pkt_inc      = 1'b1;
            end
        end
    end

    // Read side: only the committed region [rd_ptr, commit_ptr) is ever exposed
    assign rd_idx    = rd_ptr[ADDR_W-1:0];
    assign out_valid = (rd_ptr != commit_ptr);
    assign out_data  = out_valid ? mem[rd_idx] : 8'h00;
    assign out_last  = out_valid & last_mem[rd_idx];
    assign rd_fire   = out_valid & out_ready;
    assign pkt_dec   = rd_fire & last_mem[rd_idx];

    // Control registers: pointers, drop state, packet count and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_avail  <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr     <= wr_ptr_d;
            commit_ptr <= commit_ptr_d;
            overflow   <= ovf_d;
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Commit and last-byte read in the same cycle cancel out
            pkt_avail  <= pkt_avail + {{ADDR_W{1'b0}}, pkt_inc} - {{ADDR_W{1'b0}}, pkt_dec};
        end
    end

    // Byte storage; contents are left unreset because pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[wr_ptr[ADDR_W-1:0]] <= rx_data;
        end
    end

    // End-of-packet flags, written alongside each byte or back-filled when EOP follows the byte
    always_ff @(posedge clk) begin
        if (!rst && last_we) begin
            last_mem[last_addr] <= last_val;
        end
    end

`ifdef USB_RX_BUF_STATS_EN
    logic       drop_close;
    logic [7:0] drop_cnt;

    // A dropped packet is closed by its packet_done, whatever caused the drop
    assign drop_close = packet_done &&
                        (rcv_error || (state_q == ST_DROP) || (write_enable && full));

    // Saturating dropped-packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (drop_close && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign dropped_pkts = drop_cnt;
`else
    assign dropped_pkts = 8'd0;
`endif

endmodule

// File: doc/usb_rx_packet_buffer.md
# usb_rx_packet_buffer

Packet-aware receive buffer downstream of the USB receiver top level. Accepts decoded bytes on its `rx_data`/`write_enable` strobe and holds each packet tentatively until end-of-packet. Commits good packets and rolls back packets flagged by `rcv_error` or overflow. Presents committed bytes to the mining-core loader over a valid/ready stream with a last-byte marker.

## Interface
- `DEPTH`, 64: byte capacity; power of two, 4..1024.
- `ADDR_W`, $clog2(DEPTH): derived; do not override.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `rx_data` input 8: received byte, valid when `write_enable` is high.
- `write_enable` input 1: one-cycle strobe per received byte.
- `rcv_error` input 1: current packet is bad; discard it.
- `packet_done` input 1: one-cycle strobe at EOP of the current packet.
- `out_data` output 8: head byte of the committed data; 0 when `out_valid` is low.
- `out_valid` output 1: a committed byte is available.
- `out_ready` input 1: consumer accepts the byte.
- `out_last` output 1: head byte is the final byte of its packet; 0 when `out_valid` is low.
- `pkt_avail` output ADDR_W+1: count of fully committed packets not yet fully read.
- `overflow` output 1: one-cycle pulse when a byte is refused because the buffer is full.
- `dropped_pkts` output 8: dropped-packet counter (see Configuration).

## Operation
- State: `wr_ptr`, `commit_ptr`, `rd_ptr`, each ADDR_W+1 bits with wrap bit. Byte array `mem[DEPTH]` and flag array `last[DEPTH]`. A `drop` flag.
- Occupancy is `wr_ptr - rd_ptr` (modular). Full when occupancy == DEPTH.
- Write: on `write_enable` && !`drop` && !full:
  - `mem[wr_ptr]` <= `rx_data`; `last[wr_ptr]` <= 0; `wr_ptr`++.
- Write while full:
  - Byte refused; `overflow` pulses.
  - `drop` <= 1; `wr_ptr` <= `commit_ptr`.
- `write_enable` while `drop`=1: byte ignored, no overflow pulse.
- `rcv_error`:
  - `wr_ptr` <= `commit_ptr`; `drop` <= 1.
  - Wins over any simultaneous write or `packet_done`.
- `packet_done` with !`drop` and a non-empty tentative packet:
  - If `write_enable` is also high, that byte is written first and is the last byte of the packet.
  - `last[final byte]` <= 1; `commit_ptr` <= new `wr_ptr`; `pkt_avail`++.
- `packet_done` with `drop`=1:
  - `wr_ptr` <= `commit_ptr`; `drop` <= 0; packet counted as dropped.
- `packet_done` with an empty tentative packet and !`drop`: no effect.
- `packet_done` with `rcv_error` in the same cycle: packet dropped, `drop` cleared, dropped count +1.
- Read:
  - `out_valid` = (`rd_ptr` != `commit_ptr`).
  - `out_data` = `mem[rd_ptr]` (asynchronous read).
  - `out_last` = `last[rd_ptr]`.
  - On `out_valid` && `out_ready`: `rd_ptr`++. If `out_last`, `pkt_avail`--.
- Simultaneous commit and last-byte read: `pkt_avail` net unchanged.
- Reads never touch the tentative region. Commits never move `rd_ptr`.
- Reset: all pointers 0, `drop` 0, `pkt_avail` 0, `overflow` 0, `dropped_pkts` 0, `out_valid` 0, `out_data` 0, `out_last` 0. Memory contents are not reset.

## Timing
- Commit latency: the `packet_done` edge updates `commit_ptr`. `out_valid` rises combinationally in the following cycle. No byte is visible before its packet commits.
- Throughput: one write and one read per cycle, concurrently.
- A read in the same cycle as a full-condition write frees a slot only from the next cycle. Full is evaluated on the registered pointers.
- `rst` mid-packet or mid-read discards everything at the next edge. Inputs in the reset cycle are ignored.
- `overflow` is registered: it is high in the cycle after the refused write.

## Configuration
- `USB_RX_BUF_STATS_EN` defined:
  - `dropped_pkts` is an 8-bit saturating counter (stops at 255).
  - Incremented at each `packet_done` that closes a dropped packet, whether from error or overflow.
  - Cleared by `rst`.
- Not defined: `dropped_pkts` is tied to 0 and no counter logic is generated. All other behaviour is identical.

## Test plan
- Good packet: bytes 0x54,0xB4,0xA8,0xF7, `packet_done` with the last byte, `out_ready`=1.
  - Before commit: `out_valid` stays 0.
  - Then the four bytes stream in order, `out_last` on 0xF7 only; `pkt_avail` goes 1 -> 0.
- Error rollback: commit packet A (0x11,0x22), then send 0x33,0x44 and assert `rcv_error`.
  - Only 0x11,0x22 are readable; `pkt_avail`=1.
  - `dropped_pkts`=1 after the next `packet_done` (with macro).
- Overflow at DEPTH=4, `out_ready`=0: send a 5-byte packet.
  - `overflow` pulses once on the 5th byte.
  - Packet discarded: `out_valid`=0, `pkt_avail`=0.
- Wrap-around at DEPTH=4: 10 back-to-back 3-byte packets, each drained between packets.
  - All 30 bytes are read in order, with correct `out_last` placement.
- Concurrency: read packet A while writing and committing packet B in the same cycle that A's last byte is consumed.
  - `pkt_avail` stays 1; B follows A with no gap.
- Reset mid-packet: `rst` after 2 of 4 bytes, then a fresh 2-byte packet.
  - All outputs read 0 after reset; only the new packet is delivered.
